frogger_player_fsm: RTL and testbench
=====================================

# frogger_player_fsm

Parametrised successor to the single-grid Frogger controller. It owns the frog's position and adds the following on top of basic movement:
- a lives counter and a death/respawn sequence timed in frames;
- per-slot goal occupancy, with level completion when every slot is filled;
- game-over handling.

It sits between the debounced button inputs and collision detector on one side, and the renderer and score display on the other.

## Interface
Parameters:
- GRID_W, 14: number of columns; X range 0..GRID_W-1.
- GRID_H, 15: number of rows; Y range 0..GRID_H-1, goal row is 0.
- COORD_W, 6: width of the X/Y outputs.
- START_X, 6: respawn column.
- START_Y, 14: respawn row.
- LIVES, 3: lives at game start, ≥1.
- NUM_GOALS, 4: number of goal slots.
- GOAL_SHIFT, 2: goal slot index = X >> GOAL_SHIFT.
- DEATH_TICKS, 30: frame ticks spent in DYING, ≥1.
- SCORE_W, 7: score width.

Ports:
- i_Clk  in  1  system clock
- i_Rst_L  in  1  synchronous reset, active-low
- i_Game_Active  in  1  game running; low forces IDLE
- i_Up_Mvt / i_Down_Mvt / i_Left_Mvt / i_Right_Mvt  in  1 each  debounced buttons (level)
- i_Frame_Tick  in  1  one-cycle pulse per video frame
- i_Collided  in  1  frog hit a hazard this cycle
- i_Tile_Data  in  4  tile code at the current frog position (combinational from bitmap)
- o_Frogger_X  out  COORD_W  frog column
- o_Frogger_Y  out  COORD_W  frog row
- o_Score  out  SCORE_W  score
- o_Lives  out  LW = $clog2(LIVES+1)  lives remaining
- o_Goal_Mask  out  NUM_GOALS  occupied goal slots
- o_Dying  out  1  high while in DYING
- o_Game_Over  out  1  high while in GAME_OVER
- o_Level_Done  out  1  one-cycle pulse when all slots are filled

## Operation
**Reset (i_Rst_L low at an edge):**
- State IDLE; X=START_X, Y=START_Y.
- Score 0, lives LIVES, mask 0.
- Death counter 0, edge registers 0.
- All flags 0.

**Edge detection:**
- Previous-button registers update every cycle in every state.
- A button held through a respawn or state change therefore never produces a move.

**States:**
- **IDLE**
  - Entering IDLE from any state restores all reset values except the edge registers.
  - Moves to ALIVE on the first cycle i_Game_Active is high.
- **ALIVE.** The first matching rule below applies each cycle:
  - **Collision:** i_Collided → DYING; lives−1; position held.
  - **Goal row (Y==0):** with slot = X>>GOAL_SHIFT:
    - If i_Tile_Data==TILE_GOAL, slot<NUM_GOALS and the mask bit is clear:
      - set the mask bit;
      - score+1, saturating at 2^SCORE_W−1;
      - respawn at START;
      - stay ALIVE.
    - Level completion: if that makes the mask all-ones, pulse o_Level_Done and clear the mask instead of setting the bit.
    - Otherwise (not a goal tile, occupied slot, or slot out of range) → DYING with lives−1.
  - **Movement:** rising edge on a button; priority Up > Down > Left > Right; one step per edge.
    - Clamped at 0, GRID_H−1 and GRID_W−1; no wrap.
    - A blocked move produces no change.
- **DYING**
  - o_Dying=1; position frozen; buttons ignored; i_Collided ignored.
  - The death counter increments on i_Frame_Tick.
  - On the tick that brings the counter to DEATH_TICKS:
    - counter cleared;
    - if lives==0 → GAME_OVER;
    - else respawn at START → ALIVE.
- **GAME_OVER**
  - o_Game_Over=1; score, mask and position held for display.
  - Exits only via i_Game_Active low → IDLE.

**Global rule:** i_Game_Active low in ALIVE, DYING or GAME_OVER → IDLE next edge; this aborts the game.

## Timing
- All outputs are registered.
- Button rising edge sampled at edge N → new coordinate visible after edge N+1; one move per press.
- Goal decision uses the position registered at edge N and i_Tile_Data during cycle N.
  - Score, mask, respawn and o_Level_Done all take effect at edge N+1.
  - o_Level_Done lasts exactly one cycle.
- Collision in cycle N → o_Dying and decremented o_Lives visible after N+1.
- DYING lasts exactly DEATH_TICKS frame ticks; the tick that enters DYING in the same cycle is not counted.
- Collision and Y==0 in the same cycle: collision wins, with no score and no mask change.
- Collision and a button edge in the same cycle: no move.
- Lives never underflow; decrement happens only from ALIVE, and lives≥1 there by construction.
- i_Rst_L overrides everything, including mid-DYING and mid-goal.

## Structure
- Package frogger_pkg holds:
  - the state enum (IDLE, ALIVE, DYING, GAME_OVER);
  - tile codes (TILE_GOAL=4, TILE_WATER, TILE_ROAD);
  - default grid constants.
- Sub-module frogger_btn_edge:
  - 4-bit registered rising-edge detector;
  - takes clock/reset;
  - outputs one-cycle pulses up/down/left/right.
- The remainder is a single FSM with a datapath: position, lives, score, mask and death counter.

## Test plan
- Reset, Active high, press Up 3 times (release between presses) → Y goes 14→13→12→11; Up held 10 cycles → only one step.
- At X=13, press Right → X stays 13; at Y=14, press Down → no change.
- Collide with lives=3 → o_Dying, lives=2; 30 ticks later → X=6, Y=14, ALIVE; third death → after 30 ticks o_Game_Over=1, lives=0.
- Reach Y=0 at X=4 with tile 4 → mask=0b0010, score=1, respawn; reach X=5 again with tile 4 → occupied → DYING, score stays 1.
- Fill all 4 slots → o_Level_Done single pulse, mask=0, score=4.
- Collision and Y==0 in the same cycle → DYING with no score change; deassert i_Rst_L mid-DYING → all reset values on the next edge.

Source files
------------

// File: rtl/frogger_pkg.sv
// Shared types and constants for the Frogger player controller:
// FSM state encoding, bitmap tile codes, button bit positions and default grid size.
package frogger_pkg;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_ALIVE     = 2'd1,
    ST_DYING     = 2'd2,
    ST_GAME_OVER = 2'd3
  } state_e;

  localparam logic [3:0] TILE_ROAD  = 4'd1;
  localparam logic [3:0] TILE_WATER = 4'd2;
  localparam logic [3:0] TILE_GOAL  = 4'd4;

  // Bit positions inside the packed button vector fed to the edge detector.
  localparam int BTN_UP    = 3;
  localparam int BTN_DOWN  = 2;
  localparam int BTN_LEFT  = 1;
  localparam int BTN_RIGHT = 0;

  localparam int DEF_GRID_W  = 14;
  localparam int DEF_GRID_H  = 15;
  localparam int DEF_COORD_W = 6;

endpackage

// File: rtl/frogger_btn_edge.sv
// Registered rising-edge detector for the four debounced direction buttons.
// Each output is a one-cycle pulse the cycle after the button goes high.
module frogger_btn_edge (
  input  logic       i_Clk,
  input  logic       i_Rst_L,
  input  logic [3:0] i_Btn,
  output logic [3:0] o_Pulse
);

  logic [3:0] prev_q;
  logic [3:0] pulse_q;

  // NOTE: state registers use non-blocking assignment so every flop samples
  // the pre-edge value of the others, independent of statement order.
  always_ff @(posedge i_Clk) begin
    if (!i_Rst_L) begin
      prev_q  <= '0;
      pulse_q <= '0;
    end else begin
      prev_q  <= i_Btn;
      pulse_q <= i_Btn & ~prev_q;
    end
  end

  assign o_Pulse = pulse_q;

endmodule

// File: rtl/frogger_player_fsm.sv
// Frog position, lives, score and goal-slot controller with a timed death/respawn
// sequence. All outputs come straight from registers.
module frogger_player_fsm
  import frogger_pkg::*;
#(
  parameter int GRID_W      = 14,
  parameter int GRID_H      = 15,
  parameter int COORD_W     = 6,
  parameter int START_X     = 6,
  parameter int START_Y     = 14,
  parameter int LIVES       = 3,
  parameter int NUM_GOALS   = 4,
  parameter int GOAL_SHIFT  = 2,
  parameter int DEATH_TICKS = 30,
  parameter int SCORE_W     = 7
) (
  input  logic                         i_Clk,
  input  logic                         i_Rst_L,
  input  logic                         i_Game_Active,
  input  logic                         i_Up_Mvt,
  input  logic                         i_Down_Mvt,
  input  logic                         i_Left_Mvt,
  input  logic                         i_Right_Mvt,
  input  logic                         i_Frame_Tick,
  input  logic                         i_Collided,
  input  logic [3:0]                   i_Tile_Data,
  output logic [COORD_W-1:0]           o_Frogger_X,
  output logic [COORD_W-1:0]           o_Frogger_Y,
  output logic [SCORE_W-1:0]           o_Score,
  output logic [$clog2(LIVES+1)-1:0]   o_Lives,
  output logic [NUM_GOALS-1:0]         o_Goal_Mask,
  output logic                         o_Dying,
  output logic                         o_Game_Over,
  output logic                         o_Level_Done
);

  localparam int LW = $clog2(LIVES + 1);
  localparam int CW = $clog2(DEATH_TICKS + 1);
  localparam logic [COORD_W-1:0] START_XC = COORD_W'(START_X);
  localparam logic [COORD_W-1:0] START_YC = COORD_W'(START_Y);
  localparam logic [COORD_W-1:0] MAX_X    = COORD_W'(GRID_W - 1);
  localparam logic [COORD_W-1:0] MAX_Y    = COORD_W'(GRID_H - 1);

  logic [3:0] btn_pulse;

  frogger_btn_edge u_btn_edge (
    .i_Clk   (i_Clk),
    .i_Rst_L (i_Rst_L),
    .i_Btn   ({i_Up_Mvt, i_Down_Mvt, i_Left_Mvt, i_Right_Mvt}),
    .o_Pulse (btn_pulse)
  );

  state_e               state_q;
  logic [COORD_W-1:0]   x_q, y_q;
  logic [SCORE_W-1:0]   score_q;
  logic [LW-1:0]        lives_q;
  logic [NUM_GOALS-1:0] mask_q;
  logic [CW-1:0]        cnt_q;
  logic                 dying_q, game_over_q, level_done_q;

  logic [COORD_W-1:0]   x_move_d, y_move_d;
  logic [COORD_W-1:0]   slot;
  logic [NUM_GOALS-1:0] goal_bit, mask_set_d;
  logic [SCORE_W-1:0]   score_inc_d;
  logic [CW-1:0]        cnt_inc_d;
  logic                 goal_ok, death_done;

  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    x_move_d = x_q;
    y_move_d = y_q;
    // Highest-priority edge wins; if it is blocked by a border nothing moves.
    if (btn_pulse[BTN_UP]) begin
      if (y_q != '0) y_move_d = y_q - COORD_W'(1);
    end else if (btn_pulse[BTN_DOWN]) begin
      if (y_q != MAX_Y) y_move_d = y_q + COORD_W'(1);
    end else if (btn_pulse[BTN_LEFT]) begin
      if (x_q != '0) x_move_d = x_q - COORD_W'(1);
    end else if (btn_pulse[BTN_RIGHT]) begin
      if (x_q != MAX_X) x_move_d = x_q + COORD_W'(1);
    end
  end

  assign slot        = x_q >> GOAL_SHIFT;
  assign goal_bit    = NUM_GOALS'(1) << slot;
  assign mask_set_d  = mask_q | goal_bit;
  assign goal_ok     = (i_Tile_Data == TILE_GOAL) && (slot < COORD_W'(NUM_GOALS))
                       && ((mask_q & goal_bit) == '0);
  assign score_inc_d = (score_q == '1) ? score_q : score_q + SCORE_W'(1);
  assign cnt_inc_d   = cnt_q + CW'(1);
  assign death_done  = i_Frame_Tick && (cnt_inc_d == CW'(DEATH_TICKS));

  always_ff @(posedge i_Clk) begin
    // Reset and game abort both land in IDLE with fresh game values.
    if (!i_Rst_L || !i_Game_Active) begin
      state_q      <= ST_IDLE;
      x_q          <= START_XC;
      y_q          <= START_YC;
      score_q      <= '0;
      lives_q      <= LW'(LIVES);
      mask_q       <= '0;
      cnt_q        <= '0;
      dying_q      <= 1'b0;
      game_over_q  <= 1'b0;
      level_done_q <= 1'b0;
    end else begin
      level_done_q <= 1'b0;
      case (state_q)
        ST_IDLE: state_q <= ST_ALIVE;
        ST_ALIVE: begin
          if (i_Collided) begin
            state_q <= ST_DYING;
            dying_q <= 1'b1;
            lives_q <= lives_q - LW'(1);
          end else if (y_q == '0) begin
            if (goal_ok) begin
              score_q <= score_inc_d;
              x_q     <= START_XC;
              y_q     <= START_YC;
              if (&mask_set_d) begin
                mask_q       <= '0;
                level_done_q <= 1'b1;
              end else begin
                mask_q <= mask_set_d;
              end
            end else begin
              state_q <= ST_DYING;
              dying_q <= 1'b1;
              lives_q <= lives_q - LW'(1);
            end
          end else begin
            x_q <= x_move_d;
            y_q <= y_move_d;
          end
        end
        ST_DYING: begin
          if (death_done) begin
            cnt_q   <= '0;
            dying_q <= 1'b0;
            if (lives_q == '0) begin
              state_q     <= ST_GAME_OVER;
              game_over_q <= 1'b1;
            end else begin
              state_q <= ST_ALIVE;
              x_q     <= START_XC;
              y_q     <= START_YC;
            end
          end else if (i_Frame_Tick) begin
            cnt_q <= cnt_inc_d;
          end
        end
        ST_GAME_OVER: state_q <= ST_GAME_OVER;
        default:      state_q <= ST_IDLE;
      endcase
    end
  end

  assign o_Frogger_X  = x_q;
  assign o_Frogger_Y  = y_q;
  assign o_Score      = score_q;
  assign o_Lives      = lives_q;
  assign o_Goal_Mask  = mask_q;
  assign o_Dying      = dying_q;
  assign o_Game_Over  = game_over_q;
  assign o_Level_Done = level_done_q;

endmodule

// File: tb/tb_frogger_player_fsm.sv
// Directed bench for frogger_player_fsm: stimulus queues expected output snapshots,
// a negedge monitor pops and compares them against the DUT.
module tb_frogger_player_fsm;
  import frogger_pkg::*;

  logic       clk = 1'b0;
  logic       rst_l, active, frame, coll;
  logic [3:0] btn;   // [0]=up [1]=down [2]=left [3]=right
  logic [3:0] tile;

  logic [5:0] dut_x, dut_y;
  logic [6:0] dut_score;
  logic [1:0] dut_lives;
  logic [3:0] dut_mask;
  logic       dut_dying, dut_go, dut_ld;

  localparam int UP = 0, DOWN = 1, LEFT = 2, RIGHT = 3;

  frogger_player_fsm dut (
    .i_Clk         (clk),
    .i_Rst_L       (rst_l),
    .i_Game_Active (active),
    .i_Up_Mvt      (btn[0]),
    .i_Down_Mvt    (btn[1]),
    .i_Left_Mvt    (btn[2]),
    .i_Right_Mvt   (btn[3]),
    .i_Frame_Tick  (frame),
    .i_Collided    (coll),
    .i_Tile_Data   (tile),
    .o_Frogger_X   (dut_x),
    .o_Frogger_Y   (dut_y),
    .o_Score       (dut_score),
    .o_Lives       (dut_lives),
    .o_Goal_Mask   (dut_mask),
    .o_Dying       (dut_dying),
    .o_Game_Over   (dut_go),
    .o_Level_Done  (dut_ld)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed {
    int         cyc;
    logic [5:0] x;
    logic [5:0] y;
    logic [6:0] score;
    logic [1:0] lives;
    logic [3:0] mask;
    logic       dying;
    logic       go;
    logic       ld;
  } exp_t;

  exp_t  sb_q[$];
  string name_q[$];
  int    compared = 0;
  int    mismatched = 0;

  // Expected output state, set by hand alongside the stimulus.
  logic [5:0] e_x, e_y;
  logic [6:0] e_score;
  logic [1:0] e_lives;
  logic [3:0] e_mask;
  logic       e_dying, e_go, e_ld;

  task automatic set_reset_vals();
    e_x = 6; e_y = 14; e_score = 0; e_lives = 3; e_mask = 0;
    e_dying = 0; e_go = 0; e_ld = 0;
  endtask

  task automatic push(input string name);
    exp_t e;
    e.cyc = cyc; e.x = e_x; e.y = e_y; e.score = e_score; e.lives = e_lives;
    e.mask = e_mask; e.dying = e_dying; e.go = e_go; e.ld = e_ld;
    sb_q.push_back(e);
    name_q.push_back(name);
  endtask

  always @(negedge clk) begin
    exp_t  e;
    exp_t  a;
    string n;
    while (sb_q.size() != 0 && sb_q[0].cyc <= cyc) begin
      e = sb_q.pop_front();
      n = name_q.pop_front();
      a = e;
      a.x = dut_x; a.y = dut_y; a.score = dut_score; a.lives = dut_lives;
      a.mask = dut_mask; a.dying = dut_dying; a.go = dut_go; a.ld = dut_ld;
      compared++;
      if (a !== e) begin
        mismatched++;
        $display("FAIL %s: got x=%0d y=%0d score=%0d lives=%0d mask=%b dying=%b over=%b done=%b; want x=%0d y=%0d score=%0d lives=%0d mask=%b dying=%b over=%b done=%b",
                 n, a.x, a.y, a.score, a.lives, a.mask, a.dying, a.go, a.ld,
                 e.x, e.y, e.score, e.lives, e.mask, e.dying, e.go, e.ld);
      end
    end
  end

  task automatic step(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  // Press and release: the move lands on the second edge.
  task automatic press(input int b);
    btn[b] = 1'b1; step(1);
    btn[b] = 1'b0; step(1);
  endtask

  task automatic press_n(input int b, input int n);
    repeat (n) press(b);
  endtask

  task automatic frames(input int n);
    repeat (n) begin
      frame = 1'b1; step(1);
      frame = 1'b0; step(1);
    end
  endtask

  initial begin
    rst_l = 0; active = 0; frame = 0; coll = 0; btn = '0; tile = TILE_GOAL;
    step(2);
    set_reset_vals(); push("reset");
    rst_l = 1; active = 1; step(1); push("idle_to_alive");

    for (int i = 0; i < 3; i++) begin press(UP); e_y = e_y - 1; push("up_press"); end
    btn[UP] = 1; step(10); btn[UP] = 0; step(1); e_y = 10; push("up_held_once");
    press_n(DOWN, 4); e_y = 14; push("down_to_bottom");
    press(DOWN); push("down_clamp");
    press_n(RIGHT, 7); e_x = 13; push("right_to_edge");
    press(RIGHT); push("right_clamp");
    btn[UP] = 1; btn[LEFT] = 1; step(1); btn = '0; step(1); e_y = 13; push("up_beats_left");
    press(DOWN); e_y = 14; push("down_back");

    // Collision coinciding with a frame tick: that tick is not counted.
    coll = 1; frame = 1; step(1); coll = 0; frame = 0;
    e_lives = 2; e_dying = 1; push("collide");
    press(LEFT); push("dying_frozen");
    frames(29); push("dying_29_ticks");
    frames(1); e_dying = 0; e_x = 6; e_y = 14; push("respawn");

    press_n(LEFT, 2); press_n(UP, 14); e_x = 4; e_y = 0; push("at_goal_x4");
    step(1); e_mask = 4'b0010; e_score = 1; e_x = 6; e_y = 14; push("goal_slot1");

    press(LEFT); press_n(UP, 14); e_x = 5; e_y = 0; push("at_goal_x5");
    step(1); e_lives = 1; e_dying = 1; push("slot_occupied");
    frames(30); e_dying = 0; e_x = 6; e_y = 14; push("respawn2");

    press_n(RIGHT, 2); press_n(UP, 14);
    step(1); e_mask = 4'b0110; e_score = 2; push("goal_slot2");
    press_n(RIGHT, 6); press_n(UP, 14);
    step(1); e_mask = 4'b1110; e_score = 3; push("goal_slot3");
    press_n(LEFT, 6); e_x = 0; push("left_to_edge");
    press(LEFT); push("left_clamp");
    press_n(UP, 14); e_y = 0; push("at_goal_x0");
    step(1); e_mask = 0; e_score = 4; e_ld = 1; e_x = 6; e_y = 14; push("level_done");
    step(1); e_ld = 0; push("level_done_one_cycle");

    press_n(RIGHT, 2); press_n(UP, 14); e_x = 8; e_y = 0; push("at_goal_x8");
    coll = 1; step(1); coll = 0; e_lives = 0; e_dying = 1; push("collide_beats_goal");
    frames(30); e_dying = 0; e_go = 1; push("game_over");
    press(UP); step(3); push("game_over_hold");

    active = 0; step(1); set_reset_vals(); push("abort_to_idle");
    active = 1; step(1); push("restart");
    coll = 1; step(1); coll = 0; e_lives = 2; e_dying = 1; push("collide_again");
    frames(5);
    rst_l = 0; step(1); set_reset_vals(); push("reset_mid_dying");
    rst_l = 1; step(1);

    for (int i = 0; i < 20 && sb_q.size() != 0; i++) step(1);
    if (sb_q.size() != 0) begin
      $display("FAIL drain: %0d checks never reached", sb_q.size());
      mismatched += sb_q.size();
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
